// File: rtl/line_mem_responder_if.sv
// Cache-to-memory line request bus: one request per line, then a write
// burst (cache to memory) or a refill burst (memory to cache).
interface line_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] wdata;
   logic        wvalid;
   logic        wready;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;
   logic        rlast;
   logic        wack;
   logic        busy;

   modport master (
      output req_valid, req_we, req_addr, wdata, wvalid, rready,
      input  req_ready, wready, rdata, rvalid, rlast, wack, busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, wdata, wvalid, rready,
      output req_ready, wready, rdata, rvalid, rlast, wack, busy
   );
endinterface

// File: rtl/line_mem_responder.sv
// Memory-side line responder: serves one refill or writeback line at a time
// from a word-addressed array, after a fixed access latency.
module line_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LINE_WORDS  = 4,
   parameter int unsigned LATENCY     = 8
) (
   input logic                 clk,
   input logic                 rst,
   line_mem_responder_if.slave bus
);

   localparam int unsigned AW    = $clog2(DEPTH_WORDS);
   localparam int unsigned BW    = $clog2(LINE_WORDS);
   localparam int unsigned LAT_W = $clog2(LATENCY + 1);
   localparam int unsigned LW    = AW - BW;
   localparam logic [BW-1:0]    LAST_BEAT = BW'(LINE_WORDS - 1);
   localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(LATENCY - 1);

   typedef enum logic [2:0] {
      StIdle, StRLat, StRBurst, StWBurst, StWLat, StWAck
   } state_e;

   state_e            state_q, state_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [LW-1:0]     line_q, line_d;
   logic [AW-1:0]     word_idx;
   logic [31:0]       mem [DEPTH_WORDS];
   logic              unused_addr;

   // Line base has its low bits cleared, so base+beat is a plain concatenation
   // and the modulo-DEPTH_WORDS wrap falls out of the truncated width.
   assign word_idx    = {line_q, beat_q};
   assign unused_addr = ^{bus.req_addr[31:AW+2], bus.req_addr[BW+1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         beat_q  <= '0;
         lat_q   <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         lat_q   <= lat_d;
         line_q  <= line_d;
      end
   end

   // Backing array is never cleared; beats written before a reset stay.
   always_ff @(posedge clk) begin
      if (!rst && state_q == StWBurst && bus.wvalid) begin
         mem[word_idx] <= bus.wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      lat_d   = lat_q;
      line_d  = line_q;
      case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               line_d = bus.req_addr[AW+1:BW+2];
               beat_d = '0;
               lat_d  = LAT_LOAD;
               if (bus.req_we) begin
                  state_d = StWBurst;
               end else if (LATENCY == 1) begin
                  state_d = StRBurst;
               end else begin
                  state_d = StRLat;
               end
            end
         end
         StRLat: begin
            // Loaded with LATENCY-1: leaves after LATENCY-1 cycles here.
            if (lat_q == LAT_W'(1)) begin
               state_d = StRBurst;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         StRBurst: begin
            if (bus.rready) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) begin
                  state_d = StIdle;
               end
            end
         end
         StWBurst: begin
            if (bus.wvalid) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) begin
                  lat_d   = LAT_LOAD;
                  state_d = (LATENCY == 1) ? StWAck : StWLat;
               end
            end
         end
         StWLat: begin
            if (lat_q == LAT_W'(1)) begin
               state_d = StWAck;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         StWAck:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.req_ready = (state_q == StIdle);
      bus.busy      = (state_q != StIdle);
      bus.wready    = (state_q == StWBurst);
      bus.wack      = (state_q == StWAck);
      bus.rvalid    = (state_q == StRBurst);
      bus.rlast     = (state_q == StRBurst) && (beat_q == LAST_BEAT);
      bus.rdata     = '0;
      if (state_q == StRBurst) begin
         bus.rdata = mem[word_idx];
      end
   end

endmodule

// File: tb/tb_line_mem_responder.sv
// Scenario bench for line_mem_responder: refill data is scoreboarded through
// an expected-word queue filled at request time and drained per accepted beat.
module tb_line_mem_responder;

   localparam int LATENCY = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic [31:0] exp_q [$];

   line_mem_responder_if bus ();

   line_mem_responder #(
      .DEPTH_WORDS (1024),
      .LINE_WORDS  (4),
      .LATENCY     (LATENCY)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_line(input logic [31:0] addr, input logic [127:0] line, input bit gap);
      int n;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = addr;
      total++;
      if (bus.req_ready !== 1'b1) begin
         bad++; $display("FAIL wr_req_ready: got %b want 1", bus.req_ready);
      end
      step();
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (gap && i == 2) begin
            bus.wvalid = 1'b0;
            step();
         end
         bus.wvalid = 1'b1;
         bus.wdata  = line[32*i +: 32];
         total++;
         if (bus.wready !== 1'b1) begin
            bad++; $display("FAIL wr_wready beat %0d: got %b want 1", i, bus.wready);
         end
         step();
      end
      bus.wvalid = 1'b0;
      total++;
      if (bus.wready !== 1'b0 || bus.busy !== 1'b1) begin
         bad++; $display("FAIL wr_after_burst: got wready=%b busy=%b want 0 1", bus.wready, bus.busy);
      end
      n = 1;
      while (bus.wack !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      total++;
      if (n != LATENCY) begin
         bad++; $display("FAIL wr_wack_latency: got %0d want %0d", n, LATENCY);
      end
      step();
      total++;
      if (bus.wack !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
         bad++; $display("FAIL wr_wack_pulse: got wack=%b busy=%b req_ready=%b want 0 0 1",
                         bus.wack, bus.busy, bus.req_ready);
      end
   endtask

   task automatic read_line(input logic [31:0] addr, input logic [127:0] line,
                            input int stall_beat, input int stall_cyc, input bit hold_req);
      int n;
      logic [31:0] e;
      for (int i = 0; i < 4; i++) exp_q.push_back(line[32*i +: 32]);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = addr;
      total++;
      if (bus.req_ready !== 1'b1) begin
         bad++; $display("FAIL rd_req_ready: got %b want 1", bus.req_ready);
      end
      step();
      if (!hold_req) bus.req_valid = 1'b0;
      n = 1;
      while (bus.rvalid !== 1'b1 && n < 40) begin
         if (hold_req && bus.req_ready !== 1'b0) begin
            total++; bad++;
            $display("FAIL rd_busy_ready: got %b want 0", bus.req_ready);
         end
         step();
         n++;
      end
      total++;
      if (n != LATENCY) begin
         bad++; $display("FAIL rd_latency: got %0d want %0d", n, LATENCY);
      end
      for (int i = 0; i < 4; i++) begin
         if (i == stall_beat) begin
            bus.rready = 1'b0;
            for (int s = 0; s < stall_cyc; s++) begin
               total++;
               if (bus.rvalid !== 1'b1 || bus.rdata !== exp_q[0] || bus.rlast !== 1'b0) begin
                  bad++; $display("FAIL rd_stall_hold: got v=%b d=%h l=%b want 1 %h 0",
                                  bus.rvalid, bus.rdata, bus.rlast, exp_q[0]);
               end
               step();
            end
         end
         bus.rready = 1'b1;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
         total++;
         if (bus.rvalid !== 1'b1 || bus.rdata !== e) begin
            bad++; $display("FAIL rd_data beat %0d: got v=%b d=%h want 1 %h", i, bus.rvalid, bus.rdata, e);
         end
         total++;
         if (bus.rlast !== (i == 3)) begin
            bad++; $display("FAIL rd_last beat %0d: got %b want %b", i, bus.rlast, (i == 3));
         end
         if (hold_req) begin
            total++;
            if (bus.req_ready !== 1'b0) begin
               bad++; $display("FAIL rd_hold_ready beat %0d: got %b want 0", i, bus.req_ready);
            end
         end
         step();
      end
      bus.rready = 1'b0;
      total++;
      if (bus.req_ready !== 1'b1 || bus.rvalid !== 1'b0) begin
         bad++; $display("FAIL rd_done: got req_ready=%b rvalid=%b want 1 0", bus.req_ready, bus.rvalid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      total++;
      if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL reset_ctrl: got req_ready=%b busy=%b want 1 0", bus.req_ready, bus.busy);
      end
      total++;
      if (bus.rvalid !== 1'b0 || bus.rlast !== 1'b0 || bus.wready !== 1'b0 || bus.wack !== 1'b0) begin
         bad++; $display("FAIL reset_outs: got rv=%b rl=%b wr=%b wk=%b want 0 0 0 0",
                         bus.rvalid, bus.rlast, bus.wready, bus.wack);
      end
      total++;
      if (bus.rdata !== 32'h0) begin
         bad++; $display("FAIL reset_rdata: got %h want 0", bus.rdata);
      end
   endtask

   task automatic test_writeback();
      write_line(32'h40, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0);
   endtask

   task automatic test_refill();
      read_line(32'h40, {32'h44, 32'h33, 32'h22, 32'h11}, -1, 0, 1'b0);
   endtask

   task automatic test_stall();
      read_line(32'h40, {32'h44, 32'h33, 32'h22, 32'h11}, 2, 3, 1'b0);
   endtask

   task automatic test_wrap();
      // Stray write beats outside WBURST must not land in the array.
      bus.wvalid = 1'b1;
      bus.wdata  = 32'hdead_beef;
      read_line(32'h4c, {32'h44, 32'h33, 32'h22, 32'h11}, -1, 0, 1'b0);
      bus.wvalid = 1'b0;
      write_line(32'h1040, {32'h88, 32'h77, 32'h66, 32'h55}, 1'b1);
      read_line(32'h40, {32'h88, 32'h77, 32'h66, 32'h55}, -1, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      int wacks;
      int n;
      write_line(32'h80, {32'ha3, 32'ha2, 32'ha1, 32'ha0}, 1'b0);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'h80;
      step();
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.wvalid    = 1'b1;
      bus.wdata     = 32'hb0;
      step();
      bus.wdata     = 32'hb1;
      step();
      bus.wvalid    = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++;
      if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.wready !== 1'b0) begin
         bad++; $display("FAIL rstmid_wr_idle: got req_ready=%b busy=%b wready=%b want 1 0 0",
                         bus.req_ready, bus.busy, bus.wready);
      end
      wacks = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.wack === 1'b1) wacks++;
         step();
      end
      total++;
      if (wacks != 0) begin
         bad++; $display("FAIL rstmid_no_wack: got %0d pulses want 0", wacks);
      end
      read_line(32'h80, {32'ha3, 32'ha2, 32'hb1, 32'hb0}, -1, 0, 1'b0);
      // Partial refill dropped by reset.
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h80;
      step();
      bus.req_valid = 1'b0;
      n = 0;
      while (bus.rvalid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      bus.rready = 1'b1;
      step();
      bus.rready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++;
      if (bus.rvalid !== 1'b0 || bus.req_ready !== 1'b1 || bus.rdata !== 32'h0) begin
         bad++; $display("FAIL rstmid_rd_drop: got rvalid=%b req_ready=%b rdata=%h want 0 1 0",
                         bus.rvalid, bus.req_ready, bus.rdata);
      end
   endtask

   task automatic test_back_to_back();
      read_line(32'h40, {32'h88, 32'h77, 32'h66, 32'h55}, -1, 0, 1'b1);
      read_line(32'h80, {32'ha3, 32'ha2, 32'hb1, 32'hb0}, -1, 0, 1'b0);
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.wdata     = '0;
      bus.wvalid    = 1'b0;
      bus.rready    = 1'b0;
      step();
      test_reset();
      test_writeback();
      test_refill();
      test_stall();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Memory-side responder for the data cache refill/writeback interface.
- The cache acts as initiator: it issues one line request per miss (read refill or dirty writeback). This block serves the request from a word-addressed backing array, after a programmable latency, one 32-bit word per beat.
- Sits below the cache in the MEM stage; while it is busy the cache keeps holding the pipeline stall.

Parameters:
- DEPTH_WORDS, 1024: backing array size in 32-bit words; must be a power of 2.
- LINE_WORDS, 4: words per cache line (beats per burst); must be a power of 2 and at least 2.
- LATENCY, 8: access latency in cycles; must be at least 1.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- req_valid  input  1  line request valid
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = writeback line, 0 = refill line
- req_addr  input  32  byte address; low log2(LINE_WORDS)+2 bits ignored
- wdata  input  32  writeback beat data
- wvalid  input  1  writeback beat valid
- wready  output  1  responder accepts writeback beat
- rdata  output  32  refill beat data
- rvalid  output  1  refill beat valid
- rready  input  1  cache accepts refill beat
- rlast  output  1  marks the final refill beat
- wack  output  1  one-cycle pulse: writeback line committed
- busy  output  1  request in progress (high in any state other than IDLE)

Interface decision: one clock, clk. Reset rst is synchronous and active-high.

Behaviour:
- States: IDLE, RLAT, RBURST, WBURST, WLAT, WACK.
- Reset (sampled on the clk edge): state goes to IDLE; beat and latency counters clear; req_ready=1; rvalid, rlast, wready, wack and busy are 0; rdata=0.
  - The backing array is not cleared by reset. It is zero at time 0.
- IDLE:
  - req_ready=1.
  - Handshake occurs when req_valid && req_ready.
  - On handshake, latch base = req_addr[31:2] with the low log2(LINE_WORDS) bits cleared, taken modulo DEPTH_WORDS. Clear the beat counter.
  - Next state: req_we=0 goes to RLAT; req_we=1 goes to WBURST.
  - req_valid while not IDLE is ignored: no queuing, req_ready=0.
- RLAT:
  - Counts down so that the first rvalid is high exactly LATENCY cycles after the handshake cycle.
  - For LATENCY=1, the state passes straight to RBURST on the next edge.
- RBURST:
  - rvalid=1; rdata = mem[(base+beat) mod DEPTH_WORDS]; rlast = (beat == LINE_WORDS-1).
  - When rvalid && !rready, rdata, rvalid and rlast hold stable. No beat is skipped or repeated.
  - A beat is accepted on rvalid && rready.
  - On acceptance of the last beat, go to IDLE; req_ready=1 on the following cycle.
- WBURST:
  - wready=1.
  - Each wvalid && wready writes wdata to mem[(base+beat) mod DEPTH_WORDS] on that edge and increments beat. Gaps in wvalid are allowed.
  - After LINE_WORDS beats, go to WLAT. wready=0 from then on.
- WLAT: waits LATENCY-1 cycles so that wack is high exactly LATENCY cycles after the edge on which the last beat was accepted.
- WACK: wack=1 for exactly one cycle, then IDLE.
- wvalid outside WBURST is ignored: no write occurs.
- rready outside RBURST is ignored.
- Read-after-write: a refill issued after wack returns the new data.
- Reset mid-operation:
  - Any state returns to IDLE on the next edge.
  - Beats already written stay committed; no wack is issued.
  - A partial refill is dropped; rvalid=0 from the next cycle.
- Counters are sized $clog2(LINE_WORDS) bits for beat and $clog2(LATENCY+1) bits for latency.
- Word-index arithmetic wraps modulo DEPTH_WORDS. It never goes out of range.

Test Plan:
All scenarios use default parameters (LATENCY=8, LINE_WORDS=4, DEPTH_WORDS=1024).
1. Reset, then writeback to 0x40 with beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> wready high for 4 cycles; wack single pulse exactly 8 cycles after the 4th beat edge; busy low the cycle after wack.
2. Refill from 0x40 handshake at cycle T -> rvalid first at T+8; rdata 0x11, 0x22, 0x33, 0x44 with rready=1; rlast only on 0x44; req_ready=1 on the cycle after.
3. Refill from 0x40 with rready=0 for 3 cycles while beat 2 is presented -> rdata holds 0x33 and rlast stays 0 throughout; the sequence then resumes with 0x44 (rlast=1), no duplicates.
4. Refill from 0x4C -> returns line 0x40 (0x11..0x44). Writeback to 0x1040 (wraps past 4 KiB) -> refill from 0x40 returns the new data.
5. Assert rst after 2 of 4 writeback beats to 0x80 (line previously 0xA0..0xA3, new beats 0xB0, 0xB1) -> IDLE next cycle, req_ready=1, no wack; a later refill of 0x80 returns 0xB0, 0xB1, 0xA2, 0xA3.
6. Hold req_valid continuously across a refill -> req_ready=0 while busy; the second request is accepted only on the IDLE cycle after the first rlast beat is accepted.
